// File: rtl/pwm_cmp_pkg.sv
// Shared constants for the PWM compare stage: defaults, register map and FSM encodings.
package pwm_cmp_pkg;

  localparam int unsigned CMP_W_DFLT   = 18;
  localparam int unsigned REGBITS_DFLT = 3;
  localparam int unsigned STEP_W       = 8;

  localparam logic [17:0] CMP_RST_DFLT = 18'h01342;

  localparam int unsigned ADDR_B0     = 0;
  localparam int unsigned ADDR_B1     = 1;
  localparam int unsigned ADDR_B2     = 2;
  localparam int unsigned ADDR_COMMIT = 3;
  localparam int unsigned ADDR_STEP   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RAMP  = 2'd2;

endpackage

// File: rtl/pwm_cmp_slew.sv
// Combinational slew limiter: moves cur toward target by at most step (step 0 = jump).
module pwm_cmp_slew #(
  parameter int unsigned CMP_W  = 18,
  parameter int unsigned STEP_W = 8
) (
  input  logic [CMP_W-1:0]  cur,
  input  logic [CMP_W-1:0]  target,
  input  logic [STEP_W-1:0] step,
  output logic [CMP_W-1:0]  next_c,
  output logic              done_c
);

  logic             up;
  logic [CMP_W:0]   diff;
  logic [CMP_W:0]   step_x;

  always_comb begin
    up     = (target > cur);
    step_x = (CMP_W+1)'(step);
    if (up) diff = {1'b0, target} - {1'b0, cur};
    else    diff = {1'b0, cur} - {1'b0, target};
    // Final partial step lands exactly on target, so no wrap past zero or full scale.
    if ((step == '0) || (diff <= step_x)) next_c = target;
    else if (up)                          next_c = cur + CMP_W'(step);
    else                                  next_c = cur - CMP_W'(step);
    done_c = (next_c == target);
  end

endmodule

// File: rtl/pwm_cmp_stage.sv
// Assembles the compare word from register writes and commits it on PWM period ticks.
// Slew-limited commits are enabled by defining PWM_CMP_RAMP_EN.
module pwm_cmp_stage
  import pwm_cmp_pkg::*;
#(
  parameter int unsigned      CMP_W   = CMP_W_DFLT,
  parameter int unsigned      REGBITS = REGBITS_DFLT,
  parameter logic [CMP_W-1:0] CMP_RST = CMP_W'(CMP_RST_DFLT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REGBITS-1:0] reg_addr,
  input  logic [7:0]         reg_data,
  input  logic               reg_valid,
  input  logic               period_tick,
  output logic [CMP_W-1:0]   cmp_out,
  output logic               cmp_update,
  output logic               cmp_pending
);

  logic [1:0]       state_q, state_d;
  logic [CMP_W-1:0] scratch_q, scratch_d;
  logic [CMP_W-1:0] target_q, target_d;
  logic [CMP_W-1:0] cmp_q, cmp_d;
  logic             upd_q, upd_d;
  logic             pend_q, pend_d;
  logic             commit;
  logic [CMP_W-1:0] slew_next;
  logic             slew_done;

`ifdef PWM_CMP_RAMP_EN
  logic [STEP_W-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (reg_valid && (reg_addr == REGBITS'(ADDR_STEP))) step_d = reg_data[STEP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= STEP_W'(1);
    else        step_q <= step_d;
  end

  pwm_cmp_slew #(
    .CMP_W  (CMP_W),
    .STEP_W (STEP_W)
  ) u_slew (
    .cur    (cmp_q),
    .target (target_q),
    .step   (step_q),
    .next_c (slew_next),
    .done_c (slew_done)
  );
`else
  assign slew_next = target_q;
  assign slew_done = 1'b1;
`endif

  // Register decode and commit/apply state machine
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    target_d  = target_q;
    cmp_d     = cmp_q;
    upd_d     = 1'b0;
    commit    = 1'b0;

    if (reg_valid) begin
      case (reg_addr)
        REGBITS'(ADDR_B0):     scratch_d[7:0]       = reg_data;
        REGBITS'(ADDR_B1):     scratch_d[15:8]      = reg_data;
        REGBITS'(ADDR_B2):     scratch_d[CMP_W-1:16] = reg_data[CMP_W-17:0];
        REGBITS'(ADDR_COMMIT): commit               = 1'b1;
        default: ;
      endcase
    end

    if (commit) target_d = scratch_q;

    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with the commit is not consumed.
        if (commit) state_d = ST_ARMED;
      end
      ST_ARMED, ST_RAMP: begin
        if (period_tick) begin
          cmp_d = slew_next;
          upd_d = (slew_next != cmp_q);
          if (commit)         state_d = state_q;
          else if (slew_done) state_d = ST_IDLE;
          else                state_d = ST_RAMP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scratch_q <= CMP_RST;
      target_q  <= CMP_RST;
      cmp_q     <= CMP_RST;
      upd_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      target_q  <= target_d;
      cmp_q     <= cmp_d;
      upd_q     <= upd_d;
      pend_q    <= pend_d;
    end
  end

  assign cmp_out     = cmp_q;
  assign cmp_update  = upd_q;
  assign cmp_pending = pend_q;

endmodule
